uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte-wide UART transmitter (8N1, LSB first) with a small input FIFO.
- Drives serial data out of the project's bidirectional pins: tx goes to uio_out[0], and tx_oe goes to uio_oe[0].
- Host logic pushes bytes with a valid/ready handshake. The block serialises them at a fixed baud set by a clock divider.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4: FIFO entries; must be a power of two, 2..16.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ena  in  1  high = run; low = freeze the baud counter and FSM.
- wr_data  in  8  byte to enqueue.
- wr_valid  in  1  wr_data is valid this cycle.
- wr_ready  out  1  FIFO can accept a byte this cycle.
- tx  out  1  serial line; idle high.
- tx_oe  out  1  output enable for the tx pad.
- busy  out  1  high while a frame is being shifted out (any state other than IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes currently queued.

Behaviour:
- Reset values, forced on any clk edge with rst_n=0 (including mid-frame):
  - tx=1, tx_oe=0, busy=0, fifo_count=0, wr_ready=0.
  - FIFO pointers cleared; queued bytes are discarded.
  - FSM=IDLE; baud counter=0; bit index=0.
- First clk edge with rst_n=1: tx_oe goes to 1 and stays at 1 until the next reset. wr_ready becomes valid from the same cycle.
- wr_ready = (fifo_count < FIFO_DEPTH), computed combinationally from registered count, so it is independent of same-cycle pop.
- Push occurs when wr_valid && wr_ready at a clk edge. Push is unaffected by ena.
- A push while full is impossible, because wr_ready=0. Data presented while wr_ready=0 is ignored and not held internally.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Baud counter: counts 0..CLKS_PER_BIT-1. A "bit tick" is the cycle where counter==CLKS_PER_BIT-1 and ena=1.
- The FSM advances only when ena=1. With ena=0, all FSM, counter and tx values hold.
- FSM states:
  - IDLE: tx=1. If fifo_count>0, pop the head into the shift register, clear the counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. On the bit tick, go to DATA with bit index=0.
  - DATA: tx=shift[bit index], LSB first. On each bit tick, bit index increments. On the bit tick with index==7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the bit tick:
    - if fifo_count>0, pop and go directly to START (no idle gap);
    - else go to IDLE.
- tx is a registered output: it changes on the edge where the state changes.
- Latency with an empty FIFO and IDLE, ena=1:
  - push at edge N;
  - count=1 after N; pop at edge N+1;
  - tx falls at edge N+1;
  - frame length is exactly 10*CLKS_PER_BIT cycles from the falling edge.
- Back-to-back frames: the stop bit is exactly CLKS_PER_BIT cycles, and the next start bit begins on the following edge.
- The popped byte is latched at pop. A push in the same cycle does not affect the byte in flight.
- busy=1 in START, DATA and STOP; busy=0 in IDLE. busy is registered with the state.

Test Plan:
- Reset/idle, CLKS_PER_BIT=4: hold rst_n=0 for 3 cycles, then release → tx=1, busy=0, fifo_count=0, and tx_oe=1 from the first post-reset edge. Assert rst_n=0 mid-DATA → next edge tx=1, busy=0, fifo_count=0.
- Single byte, CLKS_PER_BIT=4: push 0xA5 → tx low one edge after count=1, then bits 1,0,1,0,0,1,0,1 each held 4 cycles, then stop high. Frame total is 40 cycles; busy drops right after the stop bit.
- Fill/full, FIFO_DEPTH=4: push 0x01..0x05 on consecutive cycles with wr_valid=1.
  - 0x01 is popped immediately, so 0x02..0x05 fill the FIFO; wr_ready=0 at count=4.
  - Line sequence is 0x01..0x05 with no gaps: stop→start adjacent, 50*CLKS_PER_BIT cycles total.
- Push while full: hold wr_valid with 0x77 while wr_ready=0 → 0x77 is not transmitted. Re-present it after wr_ready=1 → transmitted exactly once.
- Simultaneous push/pop: with count=4 at the end of STOP, present wr_valid → no push that cycle and count becomes 3. Push on the next cycle → count 4 and order preserved.
- ena gating: drop ena for 7 cycles mid-DATA → tx and bit position hold; the frame completes 7 cycles late with correct bits. A push during ena=0 still increments fifo_count.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 LSB-first UART transmitter fed by a small byte FIFO.
// Ports: clk, rst_n (sync, active-low), ena (run/freeze), wr_data/wr_valid/wr_ready
// (push handshake), tx/tx_oe (serial pad and its enable), busy (frame in flight),
// fifo_count (queued bytes).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          tx_oe,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [7:0]    shift;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  state_t        state;

  logic push;
  logic pop;
  logic tick;
  logic have;

  assign have = (fifo_count != '0);

  // tx_oe doubles as "out of reset", so wr_ready stays low in the reset cycle
  assign wr_ready = tx_oe && (fifo_count < (AW+1)'(FIFO_DEPTH));
  assign push = wr_valid && wr_ready;
  assign tick = ena && (cnt == CW'(CLKS_PER_BIT - 1));

  // The FSM consumes the head byte from IDLE, or at the end of a stop bit
  assign pop = ena && have &&
               ((state == IDLE) || ((state == STOP) && tick));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      tx_oe <= 1'b0;
    end else begin
      tx_oe <= 1'b1;
      if (ena) begin
        unique case (state)
          IDLE: begin
            if (have) begin
              shift <= mem[rptr];
              cnt   <= '0;
              state <= START;
              tx    <= 1'b0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (tick) begin
              cnt   <= '0;
              idx   <= '0;
              state <= DATA;
              tx    <= shift[0];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick) begin
              cnt <= '0;
              if (idx == 3'd7) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                idx <= idx + 3'd1;
                tx  <= shift[idx + 3'd1];
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick) begin
              cnt <= '0;
              if (have) begin
                // next frame starts with no idle gap
                shift <= mem[rptr];
                state <= START;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A queue/frame-timer model is compared every cycle; a line receiver pins results.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       tx;
  logic       tx_oe;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .tx(tx),
    .tx_oe(tx_oe),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus one frame timer that advances only when enabled.
  byte unsigned mq[$];
  bit           m_in = 0;
  int           m_el = 0;
  logic [9:0]   m_bits = '1;
  bit           m_oe = 0;
  bit           chk_on = 0;
  bit           rst_q = 0;
  bit           ena_q = 0;

  task automatic model_step();
    bit           rdy;
    bit           start_new;
    byte unsigned b;
    if (!rst_n) begin
      mq.delete();
      m_in = 0;
      m_el = 0;
      m_oe = 0;
    end else begin
      rdy = m_oe && (mq.size() < DEPTH);
      start_new = 0;
      if (ena) begin
        if (!m_in) begin
          start_new = (mq.size() > 0);
        end else if (m_el == 10*CPB - 1) begin
          if (mq.size() > 0) start_new = 1;
          else m_in = 0;
        end else begin
          m_el++;
        end
      end
      if (start_new) begin
        b = mq.pop_front();
        m_bits = {1'b1, b, 1'b0};
        m_in = 1;
        m_el = 0;
      end
      if (wr_valid && rdy) mq.push_back(wr_data);
      m_oe = 1;
    end
    rst_q = rst_n;
    ena_q = ena;
    chk_on = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("m_tx", tx, m_in ? m_bits[m_el / CPB] : 1'b1);
      chk("m_busy", busy, m_in);
      chk("m_oe", tx_oe, m_oe);
      chk("m_count", fifo_count, mq.size());
      chk("m_ready", wr_ready, m_oe && (mq.size() < DEPTH));
    end
  end

  // Line receiver and busy-run recorder, observing the DUT only
  byte unsigned rx_q[$];
  int           rx_start[$];
  int           runs[$];
  int           cyc = 0;
  int           run = 0;
  bit           rx_active = 0;
  int           rx_n = 0;
  logic [7:0]   rx_byte = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (chk_on) begin
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (!rst_q) begin
        rx_active = 0;
      end else if (ena_q) begin
        if (!rx_active) begin
          if (tx === 1'b0) begin
            rx_active = 1;
            rx_n = 0;
            rx_start.push_back(cyc);
          end
        end else begin
          rx_n++;
          if ((rx_n % CPB == CPB/2) && (rx_n / CPB >= 1) && (rx_n / CPB <= 8))
            rx_byte[rx_n / CPB - 1] = tx;
          if (rx_n == 9*CPB + CPB/2) begin
            rx_q.push_back(rx_byte);
            rx_active = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (!(busy === 1'b0 && fifo_count === 3'd0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < bound, 1);
  endtask

  initial begin
    logic [9:0]   pat;
    byte unsigned exp_rx[9];
    int           n;

    rst_n = 0;
    ena = 1;
    wr_valid = 0;
    wr_data = 0;

    // reset and idle
    repeat (3) @(negedge clk);
    chk("rst_oe", tx_oe, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_tx", tx, 1);
    chk("rst_count", fifo_count, 0);
    rst_n = 1;
    @(negedge clk);
    chk("first_oe", tx_oe, 1);
    chk("first_ready", wr_ready, 1);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);

    // single byte 0xA5
    wr_valid = 1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_valid = 0;
    chk("a5_count1", fifo_count, 1);
    chk("a5_tx_high", tx, 1);
    @(negedge clk);
    chk("a5_start", tx, 0);
    chk("a5_busy", busy, 1);
    chk("a5_count0", fifo_count, 0);
    pat = 10'b1_1010_0101_0;
    for (int i = 0; i < 44; i++) begin
      if ((i % 4 == 1) && (i < 40))
        chk($sformatf("a5_bit%0d", i / 4), tx, pat[i / 4]);
      if (i == 39) chk("a5_busy_end", busy, 1);
      if (i == 40) chk("a5_busy_drop", busy, 0);
      @(negedge clk);
    end

    // fill to full, one byte popped immediately
    for (int b = 1; b <= 5; b++) begin
      wr_valid = 1;
      wr_data = 8'(b);
      @(negedge clk);
    end
    wr_valid = 0;
    chk("full_count", fifo_count, 4);
    chk("full_ready", wr_ready, 0);

    // ignored while full
    wr_valid = 1;
    wr_data = 8'h66;
    repeat (5) @(negedge clk);
    wr_valid = 0;
    @(negedge clk);

    // present 0x77 until accepted
    wr_valid = 1;
    wr_data = 8'h77;
    n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", n < 200, 1);
    chk("pop_count", fifo_count, 3);
    @(negedge clk);
    wr_valid = 0;
    chk("refill_count", fifo_count, 4);
    wait_idle("fill_idle", 400);

    // ena gating mid-DATA with a push while frozen
    wr_valid = 1;
    wr_data = 8'hC3;
    @(negedge clk);
    wr_valid = 0;
    repeat (11) @(negedge clk);
    ena = 0;
    wr_valid = 1;
    wr_data = 8'h5A;
    @(negedge clk);
    wr_valid = 0;
    chk("ena_push_count", fifo_count, 1);
    repeat (6) @(negedge clk);
    ena = 1;
    wait_idle("ena_idle", 300);
    repeat (4) @(negedge clk);

    // reset mid-DATA discards frame and queue
    wr_valid = 1;
    wr_data = 8'h3C;
    @(negedge clk);
    wr_valid = 0;
    repeat (12) @(negedge clk);
    wr_valid = 1;
    wr_data = 8'h99;
    @(negedge clk);
    wr_valid = 0;
    chk("pre_rst_count", fifo_count, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_oe", tx_oe, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_oe", tx_oe, 1);
    repeat (60) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // line-level results
    exp_rx = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h77, 8'hC3, 8'h5A};
    chk("rx_n", rx_q.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rx_q.size()) chk($sformatf("rx_byte%0d", i), rx_q[i], exp_rx[i]);
    chk("starts_n", rx_start.size(), 10);
    if (rx_start.size() >= 9) begin
      for (int k = 1; k < 6; k++)
        chk($sformatf("gap%0d", k), rx_start[k+1] - rx_start[k], 40);
      chk("gap_ena", rx_start[8] - rx_start[7], 47);
    end
    chk("runs_n", runs.size(), 4);
    if (runs.size() >= 3) begin
      chk("run_a5", runs[0], 40);
      chk("run_fill", runs[1], 240);
      chk("run_ena", runs[2], 87);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
